// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, word-addressed data memory between the
// memory stage (M, port 0) and the loader/debug port (L, port 1). Every access
// runs IDLE -> ACCESS -> RESP. Out-of-range addresses never reach the memory
// and are reported as an error at ack time.
module dmem_arbiter #(
  parameter int DATA_W       = 64,
  parameter int DEPTH        = 2048,
  parameter int ADDR_W       = 11,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [63:0]       m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_ack,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [63:0]       l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              pick_l;
  logic              sel_we;
  logic [63:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              resp;
  logic              rd_ok;

  // Any address at or beyond DEPTH, including stray upper bits, is an error.
  function automatic logic addr_bad(input logic [63:0] a);
    return (a >= 64'(DEPTH));
  endfunction

  // Next-state logic: arbitrate and latch the winner's request only in IDLE.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    grant_d   = grant_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    pick_l    = 1'b0;
    sel_we    = m_we;
    sel_addr  = m_addr;
    sel_wdata = m_wdata;
    case (state_q)
      S_IDLE: begin
        if (m_req || l_req) begin
          // L wins when alone, or when it has lost STARVE_LIMIT times in a row.
          pick_l    = l_req && (!m_req || (starve_q == STARVE_MAX));
          sel_we    = pick_l ? l_we    : m_we;
          sel_addr  = pick_l ? l_addr  : m_addr;
          sel_wdata = pick_l ? l_wdata : m_wdata;
          state_d   = S_ACCESS;
          grant_d   = pick_l;
          we_d      = sel_we;
          addr_d    = sel_addr[ADDR_W-1:0];
          wdata_d   = sel_wdata;
          err_d     = addr_bad(sel_addr);
          if (pick_l) begin
            starve_d = '0;
          end else if (l_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
        grant_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; everything clears so all outputs read 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  // mem_en is gated with rst_n directly so a reset landing in ACCESS cannot commit a write.
  assign mem_en    = rst_n && (state_q == S_ACCESS) && !err_q;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign busy      = (state_q != S_IDLE);
  assign grant_id  = grant_q;

  // Response: only the winner sees ack; read data passes only for a legal read.
  assign resp    = (state_q == S_RESP);
  assign rd_ok   = resp && !we_q && !err_q;
  assign m_ack   = resp && !grant_q;
  assign l_ack   = resp && grant_q;
  assign m_err   = m_ack && err_q;
  assign l_err   = l_ack && err_q;
  assign m_rdata = (rd_ok && !grant_q) ? mem_rdata : '0;
  assign l_rdata = (rd_ok && grant_q)  ? mem_rdata : '0;

endmodule
